// File: rtl/e_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Holds the D/E pipeline register, selects forwarded operands from M and W,
// evaluates the ALU and runs a multi-cycle multiply/divide unit with HI/LO.
// Control inputs (ALUOp, ALUSrc, MDOp, ResSel, mf_ALU_*) describe the
// instruction currently held in IR_E; a flushed bubble is IR_E == 0.
module e_stage #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic [31:0] pc4,
    input  logic [31:0] pc,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] ext,
    input  logic [3:0]  ALUOp,
    input  logic        ALUSrc,
    input  logic [2:0]  MDOp,
    input  logic [1:0]  ResSel,
    input  logic [1:0]  mf_ALU_A,
    input  logic [1:0]  mf_ALU_B,
    input  logic [31:0] AO_M,
    input  logic [31:0] PC4_M,
    input  logic [31:0] WD,
    output logic [31:0] AO_E,
    output logic [31:0] RT_E_fwd,
    output logic [31:0] instr_out,
    output logic [31:0] pc4_out,
    output logic [31:0] pc_out,
    output logic        md_busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // D/E pipeline register
    logic [31:0] ir_e, pc4_e, pc_e, rs_e, rt_e, ext_e;

    // Forwarding and ALU
    logic [31:0] fwd_a, fwd_b, alu_b, alu_y;
    logic [4:0]  shamt, vshamt;

    // MDU
    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_is_op, ir_valid, md_start, md_commit;
    logic [31:0]      hi_q, lo_q, tmp_hi_q, tmp_lo_q;
    logic             tmp_we_q;
    logic [31:0]      res_hi, res_lo;
    logic             res_we;
    logic signed [63:0] sa64, sb64, prod_s;
    logic [63:0]      prod_u;
    logic signed [32:0] sdvd, sdvs, squo, srem;
    logic [31:0]      udvs, uquo, urem;
    logic             unused_div_msb;

    // D/E register: reset wins over flush, flush inserts an all-zero bubble
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            ir_e  <= '0;
            pc4_e <= '0;
            pc_e  <= '0;
            rs_e  <= '0;
            rt_e  <= '0;
            ext_e <= '0;
        end else begin
            ir_e  <= instr;
            pc4_e <= pc4;
            pc_e  <= pc;
            rs_e  <= rd1;
            rt_e  <= rd2;
            ext_e <= ext;
        end
    end

    // Operand forwarding from E register, M stage (ALU result or link address) and W stage
    always_comb begin
        fwd_a = rs_e;
        case (mf_ALU_A)
            2'd0:    fwd_a = rs_e;
            2'd1:    fwd_a = AO_M;
            2'd2:    fwd_a = PC4_M + 32'd4;
            default: fwd_a = WD;
        endcase
        fwd_b = rt_e;
        case (mf_ALU_B)
            2'd0:    fwd_b = rt_e;
            2'd1:    fwd_b = AO_M;
            2'd2:    fwd_b = PC4_M + 32'd4;
            default: fwd_b = WD;
        endcase
    end

    assign alu_b  = ALUSrc ? ext_e : fwd_b;
    assign shamt  = ir_e[10:6];
    assign vshamt = fwd_a[4:0];

    // ALU: shifts take B as the value; variable shifts take the amount from A
    always_comb begin
        alu_y = '0;
        case (ALUOp)
            4'd0:  alu_y = fwd_a + alu_b;
            4'd1:  alu_y = fwd_a - alu_b;
            4'd2:  alu_y = fwd_a | alu_b;
            4'd3:  alu_y = fwd_a & alu_b;
            4'd4:  alu_y = fwd_a ^ alu_b;
            4'd5:  alu_y = ~(fwd_a | alu_b);
            4'd6:  alu_y = {31'b0, $signed(fwd_a) < $signed(alu_b)};
            4'd7:  alu_y = {31'b0, fwd_a < alu_b};
            4'd8:  alu_y = alu_b << shamt;
            4'd9:  alu_y = alu_b >> shamt;
            4'd10: alu_y = $signed(alu_b) >>> shamt;
            4'd11: alu_y = alu_b << vshamt;
            4'd12: alu_y = alu_b >> vshamt;
            4'd13: alu_y = $signed(alu_b) >>> vshamt;
            4'd14: alu_y = alu_b;
            default: alu_y = '0;
        endcase
    end

    // Result select: ALU, HI or LO
    always_comb begin
        AO_E = '0;
        case (ResSel)
            2'd0:    AO_E = alu_y;
            2'd1:    AO_E = hi_q;
            2'd2:    AO_E = lo_q;
            default: AO_E = '0;
        endcase
    end

    assign RT_E_fwd  = fwd_b;
    assign instr_out = ir_e;
    assign pc4_out   = pc4_e;
    assign pc_out    = pc_e;

    assign md_is_op = (MDOp >= 3'd1) && (MDOp <= 3'd4);
    assign ir_valid = (ir_e != 32'd0);
    assign md_start = md_is_op && ir_valid && (state_q == MD_IDLE);
    assign md_busy  = (md_is_op && ir_valid) || (state_q == MD_BUSY);

    // Signed division is done at 33 bits so -2^31 / -1 cannot overflow;
    // a zero divisor is replaced by 1 and the result is simply not committed.
    assign sa64   = {{32{fwd_a[31]}}, fwd_a};
    assign sb64   = {{32{fwd_b[31]}}, fwd_b};
    assign prod_s = sa64 * sb64;
    assign prod_u = {32'b0, fwd_a} * {32'b0, fwd_b};
    assign sdvd   = {fwd_a[31], fwd_a};
    assign sdvs   = (fwd_b == 32'd0) ? 33'sd1 : {fwd_b[31], fwd_b};
    assign squo   = sdvd / sdvs;
    assign srem   = sdvd % sdvs;
    assign udvs   = (fwd_b == 32'd0) ? 32'd1 : fwd_b;
    assign uquo   = fwd_a / udvs;
    assign urem   = fwd_a % udvs;
    assign unused_div_msb = squo[32] ^ srem[32];

    // MDU result for the operation being started
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_we = 1'b0;
        case (MDOp)
            3'd1: begin
                {res_hi, res_lo} = prod_s;
                res_we = 1'b1;
            end
            3'd2: begin
                {res_hi, res_lo} = prod_u;
                res_we = 1'b1;
            end
            3'd3: begin
                res_lo = squo[31:0];
                res_hi = srem[31:0];
                res_we = (fwd_b != 32'd0);
            end
            3'd4: begin
                res_lo = uquo;
                res_hi = urem;
                res_we = (fwd_b != 32'd0);
            end
            default: begin
                res_hi = '0;
                res_lo = '0;
                res_we = 1'b0;
            end
        endcase
    end

    // MDU next-state: BUSY lasts exactly the loaded count, commit on the last edge
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_commit = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = (MDOp == 3'd1 || MDOp == 3'd2) ? CNT_W'(MULT_CYCLES)
                                                             : CNT_W'(DIV_CYCLES);
                end
            end
            MD_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = MD_IDLE;
                    cnt_d     = '0;
                    md_commit = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // MDU state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hold the computed result until the operation's cycle count has elapsed
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            tmp_we_q <= 1'b0;
        end else if (md_start) begin
            tmp_hi_q <= res_hi;
            tmp_lo_q <= res_lo;
            tmp_we_q <= res_we;
        end
    end

    // HI/LO: commit at the end of BUSY; mthi/mtlo only take effect while IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (md_commit) begin
            if (tmp_we_q) begin
                hi_q <= tmp_hi_q;
                lo_q <= tmp_lo_q;
            end
        end else if (state_q == MD_IDLE) begin
            if (MDOp == 3'd5) hi_q <= fwd_a;
            if (MDOp == 3'd6) lo_q <= fwd_a;
        end
    end

endmodule

// File: tb/tb_e_stage.sv
// Bench for the execute stage: directed scenarios followed by random traffic.
// A cycle-level reference model (plain arithmetic on 64-bit integers) predicts
// every output; predictions are queued and compared on the falling edge.
module tb_e_stage;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam int K_AO    = 0;
    localparam int K_RT    = 1;
    localparam int K_INSTR = 2;
    localparam int K_PC    = 3;
    localparam int K_PC4   = 4;
    localparam int K_BUSY  = 5;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [31:0] instr, pc4, pc, rd1, rd2, ext;
    logic [3:0]  ALUOp;
    logic        ALUSrc;
    logic [2:0]  MDOp;
    logic [1:0]  ResSel, mf_ALU_A, mf_ALU_B;
    logic [31:0] AO_M, PC4_M, WD;
    logic [31:0] AO_E, RT_E_fwd, instr_out, pc4_out, pc_out;
    logic        md_busy;

    always #5 clk = ~clk;

    e_stage #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .flush(flush), .instr(instr), .pc4(pc4), .pc(pc),
        .rd1(rd1), .rd2(rd2), .ext(ext), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MDOp(MDOp),
        .ResSel(ResSel), .mf_ALU_A(mf_ALU_A), .mf_ALU_B(mf_ALU_B), .AO_M(AO_M),
        .PC4_M(PC4_M), .WD(WD), .AO_E(AO_E), .RT_E_fwd(RT_E_fwd), .instr_out(instr_out),
        .pc4_out(pc4_out), .pc_out(pc_out), .md_busy(md_busy)
    );

    // scoreboard
    logic [31:0] exp_q[$];
    int          kind_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // reference model state
    logic [31:0] m_ir, m_pc4, m_pc, m_rs, m_rt, m_ext, m_hi, m_lo, p_hi, p_lo;
    bit          p_we;
    int          m_left;

    function automatic string kname(input int k);
        case (k)
            K_AO:    return "AO_E";
            K_RT:    return "RT_E_fwd";
            K_INSTR: return "instr_out";
            K_PC:    return "pc_out";
            K_PC4:   return "pc4_out";
            default: return "md_busy";
        endcase
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] sel, input logic [31:0] reg_v);
        case (sel)
            2'd0:    return reg_v;
            2'd1:    return AO_M;
            2'd2:    return PC4_M + 32'd4;
            default: return WD;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, b,
                                          input logic [4:0] sh);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a | b;
            4'd3:  return a & b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << sh;
            4'd9:  return b >> sh;
            4'd10: return sb >>> sh;
            4'd11: return b << a[4:0];
            4'd12: return b >> a[4:0];
            4'd13: return sb >>> a[4:0];
            4'd14: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] v);
        kind_q.push_back(k);
        exp_q.push_back(v);
    endtask

    // Predict all outputs for the current model state and current inputs
    task automatic chk();
        logic [31:0] a, brt, b, y;
        logic        busy;
        a   = m_fwd(mf_ALU_A, m_rs);
        brt = m_fwd(mf_ALU_B, m_rt);
        b   = ALUSrc ? m_ext : brt;
        y   = (ResSel == 2'd0) ? m_alu(ALUOp, a, b, m_ir[10:6]) :
              (ResSel == 2'd1) ? m_hi : (ResSel == 2'd2) ? m_lo : 32'd0;
        busy = ((MDOp inside {[3'd1:3'd4]}) && m_ir != 32'd0) || (m_left > 0);
        push(K_AO, y);
        push(K_RT, brt);
        push(K_INSTR, m_ir);
        push(K_PC, m_pc);
        push(K_PC4, m_pc4);
        push(K_BUSY, {31'b0, busy});
    endtask

    // Apply one rising edge to the model using the inputs the DUT just sampled
    task automatic model_edge();
        logic [31:0] a, b;
        longint      sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur, up;
        a = m_fwd(mf_ALU_A, m_rs);
        b = m_fwd(mf_ALU_B, m_rt);
        if (!reset) begin
            m_ir = 0; m_pc4 = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_ext = 0;
            m_hi = 0; m_lo = 0; p_hi = 0; p_lo = 0; p_we = 0; m_left = 0;
        end else begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0 && p_we) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end else if ((MDOp inside {[3'd1:3'd4]}) && m_ir != 32'd0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                ua = {32'b0, a};
                ub = {32'b0, b};
                p_we = 1;
                case (MDOp)
                    3'd1: {p_hi, p_lo} = sa * sb;
                    3'd2: begin
                        up = ua * ub;
                        {p_hi, p_lo} = up;
                    end
                    3'd3: begin
                        if (b == 0) p_we = 0;
                        else begin
                            sq = sa / sb;
                            sr = sa % sb;
                            p_lo = 32'(sq);
                            p_hi = 32'(sr);
                        end
                    end
                    default: begin
                        if (b == 0) p_we = 0;
                        else begin
                            uq = ua / ub;
                            ur = ua % ub;
                            p_lo = 32'(uq);
                            p_hi = 32'(ur);
                        end
                    end
                endcase
                m_left = (MDOp <= 3'd2) ? MULT_N : DIV_N;
            end else if (MDOp == 3'd5) begin
                m_hi = a;
            end else if (MDOp == 3'd6) begin
                m_lo = a;
            end
            if (flush) begin
                m_ir = 0; m_pc4 = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_ext = 0;
            end else begin
                m_ir = instr; m_pc4 = pc4; m_pc = pc; m_rs = rd1; m_rt = rd2; m_ext = ext;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic step();
        chk();
        tick();
    endtask

    task automatic load(input logic [31:0] i, p, a, b, e);
        instr = i; pc = p; pc4 = p + 32'd4; rd1 = a; rd2 = b; ext = e;
    endtask

    task automatic alu_case(input logic [31:0] i, a, b, e, input logic [3:0] op,
                            input logic src, input logic [31:0] expv);
        load(i, 32'h0000_3100, a, b, e);
        step();
        ALUOp = op;
        ALUSrc = src;
        push(K_AO, expv);
        step();
        ALUOp = 0;
        ALUSrc = 0;
    endtask

    task automatic md_run(input logic [31:0] a, b, input logic [2:0] op, input int n,
                          input logic [31:0] exp_hi, exp_lo);
        load(32'h0085_001a, 32'h0000_3200, a, b, 0);
        MDOp = 0;
        step();
        MDOp = op;
        push(K_BUSY, 1);
        step();
        MDOp = 0;
        load(0, 32'h0000_3204, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            push(K_BUSY, 1);
            step();
        end
        push(K_BUSY, 0);
        ResSel = 1;
        push(K_AO, exp_hi);
        step();
        ResSel = 2;
        push(K_AO, exp_lo);
        step();
        ResSel = 0;
    endtask

    // monitor: compare every queued prediction at the falling edge
    always @(negedge clk) begin
        int          k;
        logic [31:0] e, act;
        while (exp_q.size() > 0) begin
            k = kind_q.pop_front();
            e = exp_q.pop_front();
            case (k)
                K_AO:    act = AO_E;
                K_RT:    act = RT_E_fwd;
                K_INSTR: act = instr_out;
                K_PC:    act = pc_out;
                K_PC4:   act = pc4_out;
                default: act = {31'b0, md_busy};
            endcase
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s at %0t: got %h expected %h", kname(k), $time, act, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; flush = 0; instr = 0; pc4 = 0; pc = 0; rd1 = 0; rd2 = 0; ext = 0;
        ALUOp = 0; ALUSrc = 0; MDOp = 0; ResSel = 0; mf_ALU_A = 0; mf_ALU_B = 0;
        AO_M = 0; PC4_M = 0; WD = 0;
        tick();

        // reset state
        push(K_INSTR, 0); push(K_PC, 0); push(K_PC4, 0); push(K_AO, 0); push(K_BUSY, 0);
        step();
        reset = 1;

        // pipeline load, flush, reload
        load(32'h0085_1020, 32'h0000_3000, 1, 2, 0);
        step();
        flush = 1;
        push(K_INSTR, 32'h0085_1020); push(K_PC, 32'h0000_3000); push(K_PC4, 32'h0000_3004);
        step();
        flush = 0;
        load(32'h0085_1020, 32'h0000_3008, 1, 2, 0);
        push(K_INSTR, 0); push(K_PC, 0);
        step();

        // forwarding sources for A
        mf_ALU_A = 1; AO_M = 32'h10;
        push(K_PC, 32'h0000_3008); push(K_AO, 32'h12);
        step();
        mf_ALU_A = 2; PC4_M = 32'h3004;
        push(K_AO, 32'h0000_300a);
        step();
        mf_ALU_A = 3; WD = 7;
        push(K_AO, 32'd9);
        step();
        mf_ALU_B = 1;
        push(K_RT, 32'h10);
        step();
        mf_ALU_A = 0; mf_ALU_B = 0;

        // ALU boundary cases (instr carries shamt = 4)
        alu_case(32'h0000_0100, 32'h7fff_ffff, 32'h1, 0, 4'd0, 0, 32'h8000_0000);
        alu_case(32'h0000_0100, 32'hffff_ffff, 32'h1, 0, 4'd6, 0, 32'h1);
        alu_case(32'h0000_0100, 32'hffff_ffff, 32'h1, 0, 4'd7, 0, 32'h0);
        alu_case(32'h0000_0100, 32'h0, 32'h8000_0000, 0, 4'd10, 0, 32'hf800_0000);
        alu_case(32'h0000_0100, 32'h0, 32'h8000_0000, 0, 4'd9, 0, 32'h0800_0000);
        alu_case(32'h0000_0100, 32'h0, 32'h8000_0001, 0, 4'd8, 0, 32'h0000_0010);
        alu_case(32'h0000_0100, 32'd36, 32'h8000_0000, 0, 4'd13, 0, 32'hf800_0000);
        alu_case(32'h0000_0100, 32'h5, 32'h3, 32'h1234_0000, 4'd14, 1, 32'h1234_0000);
        alu_case(32'h0000_0100, 32'h5, 32'h3, 0, 4'd15, 0, 32'h0);
        alu_case(32'h0000_0100, 32'h5, 32'h7, 0, 4'd1, 0, 32'hffff_fffe);

        // multiply / divide
        md_run(32'hffff_fffd, 32'd5, 3'd1, MULT_N, 32'hffff_ffff, 32'hffff_fff1);
        md_run(32'hffff_fff9, 32'd2, 3'd3, DIV_N, 32'hffff_ffff, 32'hffff_fffd);
        md_run(32'd7, 32'd0, 3'd4, DIV_N, 32'hffff_ffff, 32'hffff_fffd);

        // reset in the middle of a divide discards the result
        load(32'h0085_001a, 32'h0000_3300, 32'd100, 32'd7, 0);
        step();
        MDOp = 3;
        step();
        MDOp = 0;
        load(0, 32'h0000_3304, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push(K_BUSY, 1);
            step();
        end
        reset = 0;
        push(K_BUSY, 1);
        step();
        reset = 1;
        push(K_BUSY, 0);
        ResSel = 1;
        push(K_AO, 0);
        step();
        for (int i = 0; i < 12; i++) begin
            ResSel = (i % 2 == 0) ? 2'd2 : 2'd1;
            push(K_BUSY, 0);
            push(K_AO, 0);
            step();
        end
        ResSel = 0;

        // mthi ignored while busy, effective once idle
        load(32'h0085_0018, 32'h0000_3400, 32'd2, 32'd3, 0);
        step();
        MDOp = 1;
        step();
        MDOp = 5; mf_ALU_A = 3; WD = 32'h55;
        load(0, 32'h0000_3404, 0, 0, 0);
        for (int i = 0; i < MULT_N; i++) begin
            push(K_BUSY, 1);
            step();
        end
        MDOp = 0; ResSel = 1;
        push(K_AO, 0); push(K_BUSY, 0);
        step();
        ResSel = 2;
        push(K_AO, 32'd6);
        step();
        MDOp = 5;
        step();
        MDOp = 0; ResSel = 1;
        push(K_AO, 32'h55);
        step();
        ResSel = 0; mf_ALU_A = 0;

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            reset    = ($urandom_range(0, 59) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            instr    = $urandom();
            pc       = $urandom();
            pc4      = pc + 32'd4;
            rd1      = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 20)) - 10) : $urandom();
            rd2      = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 8)) - 4) : $urandom();
            ext      = $urandom();
            ALUOp    = 4'($urandom_range(0, 15));
            ALUSrc   = 1'($urandom_range(0, 1));
            MDOp     = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 6)) : 3'd0;
            ResSel   = 2'($urandom_range(0, 3));
            mf_ALU_A = 2'($urandom_range(0, 3));
            mf_ALU_B = 2'($urandom_range(0, 3));
            AO_M     = $urandom();
            PC4_M    = $urandom();
            WD       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            step();
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/e_stage.md
Name: e_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Holds the D/E pipeline register and selects forwarded operands from M and W.
- Contains the ALU and a multi-cycle multiply/divide unit (MDU) with HI/LO registers.
- Produces the ALU/MDU result, the store data and the PC/instruction for the M stage, plus a busy flag for the hazard unit.

Parameters:
- MULT_CYCLES, 5, cycles busy after a mult/multu start.
- DIV_CYCLES, 10, cycles busy after a div/divu start.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low; clears all state when 0.
- flush  in  1  load a bubble (all-zero) into the D/E register; driven by the hazard unit on a D stall.
- instr  in  32  IR from the D stage.
- pc4  in  32  PC+4 from the D stage.
- pc  in  32  PC from the D stage.
- rd1  in  32  rs value from the D stage (already W-bypassed).
- rd2  in  32  rt value from the D stage.
- ext  in  32  extended immediate from the D stage.
- ALUOp  in  4  ALU function (see Behaviour).
- ALUSrc  in  1  B operand select: 1 = EXT_E, 0 = forwarded rt.
- MDOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- ResSel  in  2  0 ALU, 1 HI, 2 LO.
- mf_ALU_A  in  2  rs forward select: 0 RS_E, 1 AO_M, 2 PC4_M+4, 3 WD.
- mf_ALU_B  in  2  rt forward select, same encoding as mf_ALU_A.
- AO_M  in  32  M-stage ALU output.
- PC4_M  in  32  M-stage PC+4.
- WD  in  32  W-stage write data.
- AO_E  out  32  E-stage result.
- RT_E_fwd  out  32  forwarded rt value (store data).
- instr_out  out  32  IR_E.
- pc4_out  out  32  PC4_E.
- pc_out  out  32  PC_E.
- md_busy  out  1  MDU start or busy.

Behaviour:
- D/E register (IR_E, PC4_E, PC_E, RS_E, RT_E, EXT_E):
  - at posedge clk, reset=0 → all 0;
  - else flush=1 → all 0 (nop, sll $0);
  - else load the inputs.
  - flush and reset together: reset wins (same result).
- Forwarded A = mux(mf_ALU_A); forwarded B_rt = mux(mf_ALU_B). RT_E_fwd = B_rt.
- ALU B = ALUSrc ? EXT_E : B_rt. shamt = IR_E[10:6]. Variable shifts use A[4:0] as the amount and B as the value.
- ALUOp:
  - 0 add (wraps, no trap), 1 sub, 2 or, 3 and, 4 xor, 5 nor;
  - 6 slt (signed), 7 sltu;
  - 8 sll, 9 srl, 10 sra (value B, amount shamt);
  - 11 sllv, 12 srlv, 13 srav;
  - 14 pass B (lui, since EXT already shifted);
  - 15 → 0.
- AO_E is combinational: ResSel 0 ALU, 1 HI, 2 LO, 3 → 0.
- MDU states IDLE and BUSY; counter cnt.
  - start = (MDOp in 1..4) and state IDLE and not flush-bubble; operands are the forwarded A and B_rt sampled at that edge.
  - start edge → BUSY, cnt = MULT_CYCLES or DIV_CYCLES per op, product/quotient computed and held in temp registers.
  - Each BUSY cycle: cnt decrements. When cnt reaches 1, at the next edge commit HI/LO and return to IDLE. BUSY therefore lasts exactly N cycles.
  - mult/multu: {HI,LO} = 64-bit signed/unsigned product.
  - div/divu: LO = quotient, HI = remainder; signed ops truncate toward zero, remainder takes the dividend's sign.
  - Divisor 0: the op still occupies DIV_CYCLES; HI/LO are unchanged.
  - Start while BUSY: ignored; the hazard unit guarantees this does not occur.
  - mthi/mtlo: write A into HI/LO at the edge, only when IDLE; when BUSY they are ignored.
- md_busy = (MDOp in 1..4 and IR_E valid) OR state==BUSY. The hazard unit stalls any MD-class instruction in D while md_busy=1.
- Reset mid-operation: state IDLE, cnt 0, HI=LO=0, temps 0; a pending result is discarded.
- Reset values: instr_out/pc4_out/pc_out 0; AO_E 0 (ALUOp derived from nop); md_busy 0.

Test Plan:
- Pipeline/flush: load instr=0x00851020 (add), pc=0x3000, then flush=1 → next cycle instr_out=0, pc_out=0; next load without flush → pc_out tracks input.
- Forwarding: RS_E=1, AO_M=0x10, mf_ALU_A=1, RT_E=2, ALUOp=0 → AO_E=0x12; mf_ALU_A=2, PC4_M=0x3004 → A=0x3008; mf_ALU_A=3, WD=7 → AO_E=9.
- ALU edges: add 0x7FFFFFFF+1 → 0x80000000 (no trap); slt -1,1 → 1; sltu -1,1 → 0; sra 0x80000000 by 4 → 0xF8000000; srav with A=36 shifts by 4.
- mult: A=-3, B=5 → md_busy high for start cycle + 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; mfhi/mflo via ResSel returns them.
- div: -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles; divu 7/0 → HI/LO unchanged, busy for 10 cycles.
- Reset mid-div at cycle 4 (reset=0 one cycle) → md_busy=0, HI=LO=0, no later commit; mthi 0x55 while BUSY ignored, after IDLE → HI=0x55.
